// File: rtl/if_prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch unit: FSM state encoding,
// PC step and the default reset fetch address.
package if_prefetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_WAIT    = 2'd1,
      ST_DISCARD = 2'd2
   } fetch_state_t;

   localparam int unsigned PC_INC           = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_prefetch_unit_fetch_queue.sv
// Prefetch FIFO: push/pop/flush with occupancy count; the head reads as zero
// whenever the queue is empty.
module fetch_queue #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   // Flush wins over both push and pop in the same cycle.
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch unit: one outstanding fetch at a time, results buffered
// in a small queue, branch redirect flushes the queue and discards stale data.
module if_prefetch_unit
   import if_prefetch_unit_pkg::*;
#(
   parameter int              ADDR_W   = 32,
   parameter int              INST_W   = 32,
   parameter int              DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_addr,
   input  logic              freeze,
   output logic              mem_req_valid,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_req_ready,
   input  logic              mem_rsp_valid,
   input  logic [INST_W-1:0] mem_rsp_data,
   output logic              if_valid,
   output logic [ADDR_W-1:0] pc,
   output logic [INST_W-1:0] inst
);

   localparam int ENTRY_W = ADDR_W + INST_W;
   localparam int CNT_W   = $clog2(DEPTH) + 1;

   fetch_state_t        state;
   fetch_state_t        state_next;
   logic [ADDR_W-1:0]   fetch_pc;
   logic                accept;
   logic                push;
   logic                pop;
   logic                flush;
   logic [ENTRY_W-1:0]  q_head;
   logic [CNT_W-1:0]    q_count;
   logic                q_full;
   logic                q_empty;

   // Handshake: a request transfers on a cycle where mem_req_valid and
   // mem_req_ready are both high; the address is held while valid waits.
   assign accept       = mem_req_valid && mem_req_ready;
   assign mem_req_addr = fetch_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_FETCH: begin
            if (accept) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_rsp_valid) begin
               state_next = ST_FETCH;
            end else if (branch_taken) begin
               state_next = ST_DISCARD;
            end
         end
         // The old response is still in flight here, even across a new branch.
         ST_DISCARD: begin
            if (mem_rsp_valid) begin
               state_next = ST_FETCH;
            end
         end
         default: state_next = ST_FETCH;
      endcase
   end

   always_comb begin
      mem_req_valid = 1'b0;
      push          = 1'b0;
      pop           = 1'b0;
      flush         = 1'b0;
      if (!rst) begin
         flush = branch_taken;
         pop   = if_valid && !freeze && !branch_taken;
         if (state == ST_FETCH) begin
            mem_req_valid = !q_full && !branch_taken;
         end
         if (state == ST_WAIT) begin
            push = mem_rsp_valid && !branch_taken;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
      end else if (branch_taken) begin
         fetch_pc <= {branch_addr[ADDR_W-1:2], 2'b00};
      end else if (accept) begin
         fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
      end
   end

   // While waiting, fetch_pc has already stepped past the request, so it is
   // exactly the request address + 4 that the entry must carry.
   fetch_queue #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({fetch_pc, mem_rsp_data}),
      .pop       (pop),
      .flush     (flush),
      .head      (q_head),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty)
   );

   assign if_valid = !q_empty;
   assign pc       = q_head[ENTRY_W-1:INST_W];
   assign inst     = q_head[INST_W-1:0];

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_if_prefetch_unit;

   localparam int          ADDR_W   = 32;
   localparam int          INST_W   = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic              clk;
   logic              rst;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_addr;
   logic              freeze;
   logic              mem_req_valid;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_req_ready;
   logic              mem_rsp_valid;
   logic [INST_W-1:0] mem_rsp_data;
   logic              if_valid;
   logic [ADDR_W-1:0] pc;
   logic [INST_W-1:0] inst;

   if_prefetch_unit #(
      .ADDR_W   (ADDR_W),
      .INST_W   (INST_W),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .branch_taken  (branch_taken),
      .branch_addr   (branch_addr),
      .freeze        (freeze),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_req_ready (mem_req_ready),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .if_valid      (if_valid),
      .pc            (pc),
      .inst          (inst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: queued {pc, inst} entries plus the outstanding request.
   logic [63:0] exp_q[$];
   logic [31:0] m_fetch_pc;
   logic [31:0] m_req_addr;
   bit          m_out;
   bit          m_discard;
   bit          m_exp_req;
   logic [31:0] d0;
   logic [31:0] tgt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_fetch_pc = RESET_PC;
      m_req_addr = RESET_PC;
      m_out      = 1'b0;
      m_discard  = 1'b0;
   endtask

   // Drive one cycle's inputs (just after negedge), settle, compare against model.
   task automatic drive(input logic br, input logic [31:0] ba, input logic frz,
                        input logic rdy, input logic rv, input logic [31:0] rd);
      branch_taken  = br;
      branch_addr   = ba;
      freeze        = frz;
      mem_req_ready = rdy;
      mem_rsp_valid = rv;
      mem_rsp_data  = rd;
      #1;
      m_exp_req = !m_out && (exp_q.size() < DEPTH) && !br;
      chk("if_valid", 64'(if_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("head_pc", 64'(pc), 64'(exp_q[0][63:32]));
         chk("head_inst", 64'(inst), 64'(exp_q[0][31:0]));
      end else begin
         chk("empty_pc", 64'(pc), 64'h0);
         chk("empty_inst", 64'(inst), 64'h0);
      end
      chk("req_valid", 64'(mem_req_valid), 64'(m_exp_req));
      if (m_exp_req) chk("req_addr", 64'(mem_req_addr), 64'(m_fetch_pc));
   endtask

   // Apply the cycle's effect to the model, then advance to the next negedge.
   task automatic tick();
      if (branch_taken) begin
         exp_q.delete();
         if (m_out && mem_rsp_valid) begin
            m_out     = 1'b0;
            m_discard = 1'b0;
         end else if (m_out) begin
            m_discard = 1'b1;
         end
         m_fetch_pc = {branch_addr[31:2], 2'b00};
      end else begin
         if (exp_q.size() != 0 && !freeze) void'(exp_q.pop_front());
         if (m_out && mem_rsp_valid) begin
            if (!m_discard) exp_q.push_back({m_req_addr + 32'd4, mem_rsp_data});
            m_out     = 1'b0;
            m_discard = 1'b0;
         end
         if (m_exp_req && mem_req_ready) begin
            m_out      = 1'b1;
            m_req_addr = m_fetch_pc;
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step(input logic br, input logic [31:0] ba, input logic frz,
                       input logic rdy, input logic rv, input logic [31:0] rd);
      drive(br, ba, frz, rdy, rv, rd);
      tick();
   endtask

   initial begin
      rst           = 1'b1;
      branch_taken  = 1'b0;
      branch_addr   = '0;
      freeze        = 1'b0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      model_reset();
      #2;
      chk("rst_if_valid", 64'(if_valid), 64'h0);
      chk("rst_pc", 64'(pc), 64'h0);
      chk("rst_inst", 64'(inst), 64'h0);
      chk("rst_req_valid", 64'(mem_req_valid), 64'h0);
      @(negedge clk);
      rst = 1'b0;

      // Straight-line fetch from reset with 1-cycle responses.
      d0 = $urandom;
      drive(0, 0, 0, 1, 0, 0);
      chk("first_req_addr", 64'(mem_req_addr), 64'h0);
      tick();
      step(0, 0, 0, 1, 1, d0);
      drive(0, 0, 0, 1, 0, 0);
      chk("first_if_valid", 64'(if_valid), 64'h1);
      chk("first_pc", 64'(pc), 64'h4);
      chk("first_inst", 64'(inst), 64'(d0));
      tick();
      repeat (8) step(0, 0, 0, 1, m_out, $urandom);

      // Redirect to 0, then freeze so the queue fills to DEPTH.
      step(1, 0, 0, 1, m_out, $urandom);
      repeat (14) step(0, 0, 1, 1, m_out, $urandom);
      drive(0, 0, 1, 1, m_out, $urandom);
      chk("frz_full_req_valid", 64'(mem_req_valid), 64'h0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, 0);
         chk("frz_pop_pc", 64'(pc), 64'(4 * (i + 1)));
         tick();
      end

      // Branch to 0x102 while waiting: response dropped, refetch at 0x100.
      step(0, 0, 0, 1, 0, 0);
      step(1, 32'h102, 0, 1, 0, 0);
      drive(0, 0, 0, 1, 1, $urandom);
      chk("disc_if_valid", 64'(if_valid), 64'h0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk("disc_req_valid", 64'(mem_req_valid), 64'h1);
      chk("disc_req_addr", 64'(mem_req_addr), 64'h100);
      tick();

      // Ready held low for 3 cycles: address must not move.
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 0, 0, 0);
         chk("stall_req_addr", 64'(mem_req_addr), 64'h100);
         tick();
      end
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 1, 0, 1, $urandom);
      drive(0, 0, 1, 0, 0, 0);
      chk("stall_next_addr", 64'(mem_req_addr), 64'h104);
      tick();

      // Queue of 2 plus a request in flight, then asynchronous reset.
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 1, 0, 1, $urandom);
      step(0, 0, 1, 1, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      chk("pre_rst_q2_pc", 64'(pc), 64'h104);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_if_valid", 64'(if_valid), 64'h0);
      chk("arst_pc", 64'(pc), 64'h0);
      chk("arst_inst", 64'(inst), 64'h0);
      chk("arst_req_valid", 64'(mem_req_valid), 64'h0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      chk("arst_hold_req_valid", 64'(mem_req_valid), 64'h0);
      rst = 1'b0;
      step(0, 0, 0, 0, 1, $urandom);
      drive(0, 0, 0, 1, 0, 0);
      chk("stale_if_valid", 64'(if_valid), 64'h0);
      chk("restart_addr", 64'(mem_req_addr), 64'(RESET_PC));
      tick();
      step(0, 0, 1, 0, 1, $urandom);

      // Branch coinciding with a push and a pop.
      tgt = $urandom & 32'hFFFF_FFFC;
      step(0, 0, 1, 1, 0, 0);
      step(1, tgt | 32'h3, 0, 1, 1, $urandom);
      drive(0, 0, 0, 0, 0, 0);
      chk("bpp_if_valid", 64'(if_valid), 64'h0);
      chk("bpp_req_addr", 64'(mem_req_addr), 64'(tgt));
      tick();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) != 0, m_out && ($urandom_range(0, 2) != 0), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
